// File: rtl/bmp_pixel_streamer.sv
// Streams a BMP pixel array (BGR, 3 bytes/pixel, rows padded to 4 bytes) out of a
// byte-wide memory as one 24-bit pixel per valid/ready handshake with hsync/vsync.
module bmp_pixel_streamer #(
   parameter int WIDTH      = 16,
   parameter int HEIGHT     = 16,
   parameter int PIXEL_SIZE = 24,
   parameter int WORD_SIZE  = 8,
   parameter int ADDR_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [WORD_SIZE-1:0]  rd_data,
   input  logic                  ready,
   output logic                  valid,
   output logic [PIXEL_SIZE-1:0] data,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  busy,
   output logic                  done
);

   localparam int BPR    = 3 * WIDTH;
   localparam int PAD    = (4 - BPR % 4) % 4;
   localparam int STRIDE = BPR + PAD;
   localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);
   localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TWO_A    = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] THREE_A  = ADDR_WIDTH'(3);
   localparam logic [CW-1:0]         C_LAST   = CW'(WIDTH - 1);
   localparam logic [RW-1:0]         R_LAST   = RW'(HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP, S_OUT, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
   logic [ADDR_WIDTH-1:0] pix_addr_q, pix_addr_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [WORD_SIZE-1:0]  b0_q, b0_d, b1_q, b1_d;
   logic [PIXEL_SIZE-1:0] data_q, data_d;
   logic                  last_pix;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         pix_addr_q <= '0;
         rd_addr_q  <= '0;
         b0_q       <= '0;
         b1_q       <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         row_base_q <= row_base_d;
         pix_addr_q <= pix_addr_d;
         rd_addr_q  <= rd_addr_d;
         b0_q       <= b0_d;
         b1_q       <= b1_d;
         data_q     <= data_d;
      end
   end

   assign last_pix = (row_q == R_LAST) && (col_q == C_LAST);

   // rd_addr is loaded on entry to each read state so it is valid for that whole cycle
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      row_base_d = row_base_q;
      pix_addr_d = pix_addr_q;
      rd_addr_d  = rd_addr_q;
      b0_d       = b0_q;
      b1_d       = b1_q;
      data_d     = data_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_RD0;
               col_d      = '0;
               row_d      = '0;
               row_base_d = '0;
               pix_addr_d = '0;
               rd_addr_d  = '0;
            end
         end
         S_RD0: begin
            state_d   = S_RD1;
            rd_addr_d = pix_addr_q + ONE_A;
         end
         S_RD1: begin
            state_d   = S_RD2;
            b0_d      = rd_data;
            rd_addr_d = pix_addr_q + TWO_A;
         end
         S_RD2: begin
            state_d = S_CAP;
            b1_d    = rd_data;
         end
         S_CAP: begin
            state_d = S_OUT;
            data_d  = PIXEL_SIZE'({rd_data, b1_q, b0_q});
         end
         S_OUT: begin
            if (ready) begin
               if (last_pix) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RD0;
                  if (col_q == C_LAST) begin
                     col_d      = '0;
                     row_d      = row_q + RW'(1);
                     row_base_d = row_base_q + STRIDE_A;
                     pix_addr_d = row_base_q + STRIDE_A;
                     rd_addr_d  = row_base_q + STRIDE_A;
                  end else begin
                     col_d      = col_q + CW'(1);
                     pix_addr_d = pix_addr_q + THREE_A;
                     rd_addr_d  = pix_addr_q + THREE_A;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign rd_en   = (state_q == S_RD0) || (state_q == S_RD1) || (state_q == S_RD2);
   assign rd_addr = rd_addr_q;
   assign valid   = (state_q == S_OUT);
   assign data    = data_q;
   assign hsync   = valid && (col_q == '0);
   assign vsync   = valid && (col_q == '0) && (row_q == '0);
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_bmp_pixel_streamer.sv
// Bench for bmp_pixel_streamer: a 2x2 (padded) and a 4x3 (unpadded) instance, each with
// its own byte memory, checked against a pixel list derived from the BMP layout rules.
module tb_bmp_pixel_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_s   [2];
   logic        ready_s   [2];
   logic        rd_en_s   [2];
   logic [19:0] rd_addr_s [2];
   logic [7:0]  rd_data_s [2];
   logic        valid_s   [2];
   logic [23:0] data_s    [2];
   logic        hsync_s   [2];
   logic        vsync_s   [2];
   logic        busy_s    [2];
   logic        done_s    [2];

   logic [7:0]  mem [2][64];
   int          pad_err [2];
   int          W_  [2] = '{2, 4};
   int          H_  [2] = '{2, 3};
   int          ST_ [2] = '{8, 12};
   logic [23:0] got [$];
   int          tests  = 0;
   int          failed = 0;

   always #5 clk = ~clk;

   bmp_pixel_streamer #(.WIDTH(2), .HEIGHT(2)) dut0 (
      .clk(clk), .reset(rst_n), .start(start_s[0]), .rd_en(rd_en_s[0]),
      .rd_addr(rd_addr_s[0]), .rd_data(rd_data_s[0]), .ready(ready_s[0]),
      .valid(valid_s[0]), .data(data_s[0]), .hsync(hsync_s[0]), .vsync(vsync_s[0]),
      .busy(busy_s[0]), .done(done_s[0])
   );

   bmp_pixel_streamer #(.WIDTH(4), .HEIGHT(3)) dut1 (
      .clk(clk), .reset(rst_n), .start(start_s[1]), .rd_en(rd_en_s[1]),
      .rd_addr(rd_addr_s[1]), .rd_data(rd_data_s[1]), .ready(ready_s[1]),
      .valid(valid_s[1]), .data(data_s[1]), .hsync(hsync_s[1]), .vsync(vsync_s[1]),
      .busy(busy_s[1]), .done(done_s[1])
   );

   // Synchronous-read memories; padding or out-of-frame reads are tallied
   always @(posedge clk) begin
      if (rd_en_s[0]) begin
         rd_data_s[0] <= mem[0][rd_addr_s[0][5:0]];
         if ((rd_addr_s[0] % 8) >= 6 || rd_addr_s[0] >= 16) pad_err[0] <= pad_err[0] + 1;
      end
      if (rd_en_s[1]) begin
         rd_data_s[1] <= mem[1][rd_addr_s[1][5:0]];
         if (rd_addr_s[1] >= 36) pad_err[1] <= pad_err[1] + 1;
      end
   end

   function automatic int exp_addr(input int s, input int k);
      return (k / W_[s]) * ST_[s] + 3 * (k % W_[s]);
   endfunction

   function automatic logic [23:0] exp_pix(input int s, input int k);
      int a;
      a = exp_addr(s, k);
      return {mem[s][a+2], mem[s][a+1], mem[s][a]};
   endfunction

   task automatic fill_mem(input int s, input bit rnd);
      for (int i = 0; i < 64; i++) mem[s][i] = rnd ? 8'($urandom) : 8'(i);
   endtask

   task automatic check_zero(input int s, input string tag);
      tests++;
      if (rd_en_s[s] !== 1'b0 || rd_addr_s[s] !== 20'd0 || valid_s[s] !== 1'b0 ||
          data_s[s] !== 24'd0 || hsync_s[s] !== 1'b0 || vsync_s[s] !== 1'b0 ||
          busy_s[s] !== 1'b0 || done_s[s] !== 1'b0) begin
         failed++;
         $display("FAIL %s s=%0d: rd_en=%b addr=%h valid=%b data=%h h=%b v=%b busy=%b done=%b, expected all 0",
                  tag, s, rd_en_s[s], rd_addr_s[s], valid_s[s], data_s[s], hsync_s[s],
                  vsync_s[s], busy_s[s], done_s[s]);
      end
   endtask

   // Runs one whole frame. rp: ready probability in percent; hold: keep start high for
   // the frame and through DONE; bp: hold ready low 3 cycles for every pixel.
   task automatic run_frame(input int s, input int rp, input bit hold, input bit bp);
      int          n, k, cyc, stall, pe0;
      bit          seen_done, last_acc, prev_stall, next_rd;
      logic [23:0] pd;
      logic        ph, pv;
      n = W_[s] * H_[s]; k = 0; cyc = 0; stall = 0; pe0 = pad_err[s];
      seen_done = 0; last_acc = 0; prev_stall = 0; next_rd = 0;
      pd = '0; ph = 0; pv = 0;
      got.delete();
      @(negedge clk); start_s[s] = 1'b1;
      @(negedge clk); if (!hold) start_s[s] = 1'b0;
      tests++;
      if (rd_en_s[s] !== 1'b1 || rd_addr_s[s] !== 20'd0) begin
         failed++;
         $display("FAIL first_rd s=%0d: rd_en=%b addr=%0d, expected 1 / 0", s, rd_en_s[s], rd_addr_s[s]);
      end
      while (!seen_done && cyc < 3000) begin
         if (bp) ready_s[s] = valid_s[s] && (stall == 3);
         else    ready_s[s] = ($urandom_range(99) < rp);
         if (prev_stall) begin
            tests++;
            if (valid_s[s] !== 1'b1 || data_s[s] !== pd || hsync_s[s] !== ph ||
                vsync_s[s] !== pv || rd_en_s[s] !== 1'b0) begin
               failed++;
               $display("FAIL stall_hold s=%0d: valid=%b data=%h h=%b v=%b rd_en=%b, expected 1 %h %b %b 0",
                        s, valid_s[s], data_s[s], hsync_s[s], vsync_s[s], rd_en_s[s], pd, ph, pv);
            end
         end
         if (next_rd) begin
            tests++;
            if (rd_en_s[s] !== 1'b1 || rd_addr_s[s] !== 20'(exp_addr(s, k))) begin
               failed++;
               $display("FAIL next_rd s=%0d pix=%0d: rd_en=%b addr=%0d, expected 1 / %0d",
                        s, k, rd_en_s[s], rd_addr_s[s], exp_addr(s, k));
            end
         end
         if (done_s[s] || last_acc) begin
            tests++;
            if (done_s[s] !== last_acc || busy_s[s] !== 1'b1) begin
               failed++;
               $display("FAIL done s=%0d: done=%b busy=%b, expected %b / 1", s, done_s[s], busy_s[s], last_acc);
            end
            seen_done = 1;
         end
         last_acc = 0; next_rd = 0; prev_stall = 0;
         if (valid_s[s] && !seen_done) begin
            tests++;
            if (k >= n || data_s[s] !== exp_pix(s, k) || hsync_s[s] !== ((k % W_[s]) == 0) ||
                vsync_s[s] !== (k == 0) || busy_s[s] !== 1'b1) begin
               failed++;
               $display("FAIL pixel s=%0d k=%0d: data=%h h=%b v=%b busy=%b, expected %h %b %b 1",
                        s, k, data_s[s], hsync_s[s], vsync_s[s], busy_s[s], exp_pix(s, k),
                        (k % W_[s]) == 0, k == 0);
            end
            if (ready_s[s]) begin
               got.push_back(data_s[s]);
               k++; stall = 0;
               last_acc = (k == n);
               next_rd  = (k < n);
            end else begin
               stall++; prev_stall = 1;
               pd = data_s[s]; ph = hsync_s[s]; pv = vsync_s[s];
            end
         end
         if (!seen_done) begin
            @(negedge clk); cyc++;
         end
      end
      if (hold) @(negedge clk);
      start_s[s] = 1'b0;
      ready_s[s] = 1'b0;
      tests++;
      if (!seen_done || k != n) begin
         failed++;
         $display("FAIL frame s=%0d: accepted %0d done=%b, expected %0d / 1", s, k, seen_done, n);
      end
      tests++;
      if (pad_err[s] != pe0) begin
         failed++;
         $display("FAIL pad_read s=%0d: %0d bad reads, expected 0", s, pad_err[s] - pe0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin start_s[s] = 0; ready_s[s] = 0; pad_err[s] = 0; end
      repeat (3) @(negedge clk);
      check_zero(0, "reset");
      check_zero(1, "reset");
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [23:0] expv [4];
      expv = '{24'h020100, 24'h050403, 24'h0A0908, 24'h0D0C0B};
      fill_mem(0, 0);
      run_frame(0, 100, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= got.size() || got[i] !== expv[i]) begin
            failed++;
            $display("FAIL basic_pix%0d: got %h, expected %h", i, (i < got.size()) ? got[i] : 24'hx, expv[i]);
         end
      end
   endtask

   task automatic test_latency();
      int cyc;
      fill_mem(0, 1);
      ready_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (rd_en_s[0] !== 1'b1 || rd_addr_s[0] !== 20'(i) || valid_s[0] !== 1'b0) begin
            failed++;
            $display("FAIL lat_rd%0d: rd_en=%b addr=%0d valid=%b, expected 1 / %0d / 0", i, rd_en_s[0], rd_addr_s[0], valid_s[0], i);
         end
         @(negedge clk);
      end
      tests++;
      if (rd_en_s[0] !== 1'b0 || valid_s[0] !== 1'b0 || rd_addr_s[0] !== 20'd2) begin
         failed++;
         $display("FAIL lat_cap: rd_en=%b valid=%b addr=%0d, expected 0 / 0 / 2", rd_en_s[0], valid_s[0], rd_addr_s[0]);
      end
      @(negedge clk);
      tests++;
      if (valid_s[0] !== 1'b1 || hsync_s[0] !== 1'b1 || vsync_s[0] !== 1'b1 || data_s[0] !== exp_pix(0, 0)) begin
         failed++;
         $display("FAIL lat_out: valid=%b h=%b v=%b data=%h, expected 1 1 1 %h", valid_s[0], hsync_s[0], vsync_s[0], data_s[0], exp_pix(0, 0));
      end
      cyc = 0;
      while (!done_s[0] && cyc < 60) begin @(negedge clk); cyc++; end
      tests++;
      if (done_s[0] !== 1'b1) begin
         failed++;
         $display("FAIL lat_finish: done=%b after %0d cycles, expected 1", done_s[0], cyc);
      end
      ready_s[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      fill_mem(0, 1);
      run_frame(0, 0, 0, 1);
      fill_mem(1, 1);
      run_frame(1, 60, 0, 0);
   endtask

   task automatic test_start_ignored();
      int busy_cyc;
      fill_mem(1, 1);
      run_frame(1, 70, 1, 0);
      busy_cyc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy_s[1] || valid_s[1] || rd_en_s[1]) busy_cyc++;
      end
      tests++;
      if (busy_cyc != 0) begin
         failed++;
         $display("FAIL start_ignored: %0d active cycles after frame, expected 0", busy_cyc);
      end
   endtask

   task automatic test_reset_mid();
      int acc, cyc;
      fill_mem(1, 1);
      ready_s[1] = 1'b1;
      @(negedge clk); start_s[1] = 1'b1;
      @(negedge clk); start_s[1] = 1'b0;
      acc = 0; cyc = 0;
      while (acc < 5 && cyc < 200) begin
         @(negedge clk); cyc++;
         if (valid_s[1] && ready_s[1]) acc++;
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero(1, "reset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      ready_s[1] = 1'b0;
      run_frame(1, 100, 0, 0);
   endtask

   task automatic test_frame_4x3();
      fill_mem(1, 1);
      run_frame(1, 100, 0, 0);
      tests++;
      if (got.size() != 12) begin
         failed++;
         $display("FAIL frame4x3_count: %0d pixels, expected 12", got.size());
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_latency();
      test_backpressure();
      test_start_ignored();
      test_reset_mid();
      test_frame_4x3();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
